// File: rtl/pp_fifo_pkg.sv
// Shared helpers for the pp_pipeline_accel stream FIFO: width math and the
// empty encoding of the count-1 storage pointer.
package pp_fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    int unsigned x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Occupancy width covering 0..depth+oreg.
  function automatic int unsigned cnt_w(input int unsigned depth, input int unsigned oreg);
    return clog2(depth + oreg + 1);
  endfunction

  // Pointer width holding -1..depth-1 without aliasing the all-ones empty code.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  localparam logic [31:0] PTR_EMPTY = '1;

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl.sv
// Shift-register storage: every enabled write shifts in at index 0; the
// read port is an unregistered mux on the given address.
module pp_pipeline_accel_fifo_srl
  import pp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned DEPTH      = 3,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  ce_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ce_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout_o = sr_q[raddr_i];

endmodule

// File: rtl/pp_pipeline_accel_fifo_param.sv
// Parametrised stream FIFO with optional output register and almost flags.
// Define PP_FIFO_ERR_FLAGS_EN to add sticky if_overflow / if_underflow outputs.
module pp_pipeline_accel_fifo_param
  import pp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned AFULL_THR  = DEPTH - 1,
  parameter int unsigned AEMPTY_THR = 1,
  localparam int unsigned CNT_W     = cnt_w(DEPTH, OUT_REG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_W-1:0]      if_num_data_valid,
  output logic [CNT_W-1:0]      if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty
`ifdef PP_FIFO_ERR_FLAGS_EN
  ,
  output logic                  if_overflow,
  output logic                  if_underflow
`endif
);

  localparam int unsigned PW  = ptr_w(DEPTH);
  localparam int unsigned AW  = clog2(DEPTH);
  localparam int unsigned CAP = DEPTH + OUT_REG;
  localparam logic [PW-1:0] P_EMPTY = PW'(PTR_EMPTY);

  logic [PW-1:0]         p_q, p_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;

  logic                  clr, push, pop, load, stor_ne, shift_ce;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] srl_dout;

  pp_pipeline_accel_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk     (clk),
    .ce_i    (shift_ce),
    .din_i   (if_din),
    .raddr_i (raddr),
    .dout_o  (srl_dout)
  );

  // Next-state: pointer, occupancy, output register and registered flags.
  always_comb begin
    p_d      = p_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    oreg_d   = oreg_q;
    load     = 1'b0;
    clr      = reset | if_flush;
    push     = if_write & if_write_ce & full_n_q;
    pop      = if_read & if_read_ce & empty_n_q;
    stor_ne  = (p_q != P_EMPTY);
    raddr    = stor_ne ? AW'(p_q) : '0;
    shift_ce = push & ~clr;

    if (OUT_REG != 0) begin
      // Output register refills from storage whenever it is empty or being drained.
      load = (~ov_q | pop) & stor_ne;
      if (load) begin
        oreg_d = srl_dout;
        ov_d   = 1'b1;
      end else if (pop) begin
        ov_d   = 1'b0;
      end
      p_d = p_q + PW'(push) - PW'(load);
    end else begin
      p_d = p_q + PW'(push) - PW'(pop);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (clr) begin
      p_d   = P_EMPTY;
      cnt_d = '0;
      ov_d  = 1'b0;
    end

    full_n_d  = (cnt_d != CNT_W'(CAP));
    empty_n_d = (OUT_REG != 0) ? ov_d : (p_d != P_EMPTY);
  end

  always_ff @(posedge clk) begin
    p_q       <= p_d;
    cnt_q     <= cnt_d;
    ov_q      <= ov_d;
    oreg_q    <= oreg_d;
    full_n_q  <= full_n_d;
    empty_n_q <= empty_n_d;
  end

  assign if_dout           = (OUT_REG != 0) ? oreg_q : srl_dout;
  assign if_empty_n        = empty_n_q;
  assign if_full_n         = full_n_q;
  assign if_num_data_valid = cnt_q;
  assign if_fifo_cap       = CNT_W'(CAP);
  assign if_almost_full    = (32'(cnt_q) >= AFULL_THR);
  assign if_almost_empty   = (32'(cnt_q) <= AEMPTY_THR);

`ifdef PP_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky request-against-full/empty flags; flush deliberately leaves them set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (if_write & if_write_ce & ~full_n_q) ovf_q <= 1'b1;
      if (if_read & if_read_ce & ~empty_n_q)  unf_q <= 1'b1;
    end
  end

  assign if_overflow  = ovf_q;
  assign if_underflow = unf_q;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_param.sv
// Bench for pp_pipeline_accel_fifo_param: OUT_REG=0 and OUT_REG=1 instances
// driven in lockstep and compared against queue-based reference models.
module tb_pp_pipeline_accel_fifo_param;
  import pp_fifo_pkg::*;

  localparam int unsigned DW  = 11;
  localparam int unsigned D   = 3;
  localparam int unsigned CW0 = cnt_w(D, 0);
  localparam int unsigned CW1 = cnt_w(D, 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, fl, wr, wce, rd, rce;
  logic [DW-1:0] din;

  logic          full_n0, empty_n0, af0, ae0;
  logic [DW-1:0] dout0;
  logic [CW0-1:0] cnt0, cap0;
  logic          full_n1, empty_n1, af1, ae1;
  logic [DW-1:0] dout1;
  logic [CW1-1:0] cnt1, cap1;
`ifdef PP_FIFO_ERR_FLAGS_EN
  logic ovf0_o, unf0_o, ovf1_o, unf1_o;
`endif

  pp_pipeline_accel_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(D), .OUT_REG(0), .AFULL_THR(2), .AEMPTY_THR(1)
  ) dut0 (
    .clk(clk), .reset(reset), .if_flush(fl),
    .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(full_n0),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout0), .if_empty_n(empty_n0),
    .if_num_data_valid(cnt0), .if_fifo_cap(cap0),
    .if_almost_full(af0), .if_almost_empty(ae0)
`ifdef PP_FIFO_ERR_FLAGS_EN
    , .if_overflow(ovf0_o), .if_underflow(unf0_o)
`endif
  );

  pp_pipeline_accel_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(D), .OUT_REG(1), .AFULL_THR(2), .AEMPTY_THR(1)
  ) dut1 (
    .clk(clk), .reset(reset), .if_flush(fl),
    .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(full_n1),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout1), .if_empty_n(empty_n1),
    .if_num_data_valid(cnt1), .if_fifo_cap(cap1),
    .if_almost_full(af1), .if_almost_empty(ae1)
`ifdef PP_FIFO_ERR_FLAGS_EN
    , .if_overflow(ovf1_o), .if_underflow(unf1_o)
`endif
  );

  // Reference state: q0 is the whole FIFO; s1 is storage plus (ov1, ow1) head word.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] s1[$];
  bit            ov1;
  logic [DW-1:0] ow1;
  bit            ovf0, unf0, ovf1, unf1;
  int            ncmp = 0;
  int            nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit full0, emp0, full1, emp1;
    int occ1;
    full0 = (q0.size() == D);
    emp0  = (q0.size() == 0);
    occ1  = s1.size() + int'(ov1);
    full1 = (occ1 == D + 1);
    emp1  = !ov1;
    if (reset) begin
      ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0;
    end else begin
      if (wr && wce && full0) ovf0 = 1;
      if (rd && rce && emp0)  unf0 = 1;
      if (wr && wce && full1) ovf1 = 1;
      if (rd && rce && emp1)  unf1 = 1;
    end
    if (reset || fl) begin
      q0.delete();
      s1.delete();
      ov1 = 0;
    end else begin
      if (rd && rce && !emp0) void'(q0.pop_front());
      if (wr && wce && !full0) q0.push_back(din);
      if (rd && rce && ov1) ov1 = 0;
      // Head word comes only from storage, so a fresh write takes two cycles to show.
      if (!ov1 && s1.size() > 0) begin
        ow1 = s1.pop_front();
        ov1 = 1;
      end
      if (wr && wce && !full1) s1.push_back(din);
    end
  endtask

  task automatic check_all();
    int occ1;
    occ1 = s1.size() + int'(ov1);
    chk("d0_empty_n", 32'(empty_n0), 32'(q0.size() != 0));
    chk("d0_full_n",  32'(full_n0),  32'(q0.size() < D));
    chk("d0_count",   32'(cnt0),     32'(q0.size()));
    chk("d0_cap",     32'(cap0),     32'(D));
    chk("d0_afull",   32'(af0),      32'(q0.size() >= 2));
    chk("d0_aempty",  32'(ae0),      32'(q0.size() <= 1));
    if (q0.size() > 0) chk("d0_dout", 32'(dout0), 32'(q0[0]));
    chk("d1_empty_n", 32'(empty_n1), 32'(ov1));
    chk("d1_full_n",  32'(full_n1),  32'(occ1 < D + 1));
    chk("d1_count",   32'(cnt1),     32'(occ1));
    chk("d1_cap",     32'(cap1),     32'(D + 1));
    chk("d1_afull",   32'(af1),      32'(occ1 >= 2));
    chk("d1_aempty",  32'(ae1),      32'(occ1 <= 1));
    if (ov1) chk("d1_dout", 32'(dout1), 32'(ow1));
`ifdef PP_FIFO_ERR_FLAGS_EN
    chk("d0_overflow",  32'(ovf0_o), 32'(ovf0));
    chk("d0_underflow", 32'(unf0_o), 32'(unf0));
    chk("d1_overflow",  32'(ovf1_o), 32'(ovf1));
    chk("d1_underflow", 32'(unf1_o), 32'(unf1));
`endif
  endtask

  task automatic step(input bit w, input bit r, input bit we, input bit re,
                      input logic [DW-1:0] d, input bit f);
    wr = w; rd = r; wce = we; rce = re; din = d; fl = f;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic put(input logic [DW-1:0] d);  step(1, 0, 1, 1, d, 0); endtask
  task automatic get();                        step(0, 1, 1, 1, '0, 0); endtask
  task automatic idle();                       step(0, 0, 1, 1, '0, 0); endtask

  initial begin
    reset = 1; fl = 0; wr = 0; rd = 0; wce = 1; rce = 1; din = '0;
    ov1 = 0; ow1 = '0;
    idle();
    idle();
    reset = 0;
    idle();

    // Fill, write against full (DUT0), drain in order.
    put(11'h0A1); put(11'h0B2); put(11'h0C3);
    put(11'h0D4);
    get(); get(); get(); get();
    get(); get();

    // Single-write latency on the registered-output instance.
    put(11'h155);
    idle(); idle();
    get(); idle();

    // Sustained simultaneous read/write at occupancy 1.
    put(11'h001);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, DW'(i + 2), 0);
    for (int i = 0; i < 5; i++) get();

    // Clock enables low: requests ignored.
    step(1, 0, 0, 1, 11'h3FF, 0);
    put(11'h222);
    step(0, 1, 1, 0, '0, 0);
    get(); get(); get();

    // Flush with a concurrent write at occupancy 2, then the same with reset.
    put(11'h301); put(11'h302);
    step(1, 0, 1, 1, 11'h303, 1);
    idle();
    put(11'h311); put(11'h312);
    reset = 1;
    step(1, 0, 1, 1, 11'h313, 0);
    reset = 0;
    idle();

    // Overflow/underflow: fill past capacity, flush keeps sticky flags, reset clears.
    for (int i = 0; i < 5; i++) put(DW'(11'h400 + i));
    step(0, 0, 1, 1, '0, 1);
    get();
    idle();
    reset = 1;
    idle();
    reset = 0;
    idle();

    // Random traffic: write-heavy, read-heavy, then balanced with rare flush/reset.
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, DW'($urandom), 0);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, DW'($urandom), 0);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
           DW'($urandom), $urandom_range(0, 39) == 0);
    end
    reset = 0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_fifo_param.md
Name: pp_pipeline_accel_fifo_param

Overview:
Generic parametrised stream FIFO for the pp_pipeline_accel dataflow region, replacing the fixed-width, fixed-depth per-channel FIFO variants.
- Shift-register storage of any depth ≥ 2.
- Optional registered output stage for timing closure.
- Programmable almost-full / almost-empty flags.
- Synchronous flush.
- Sits between HLS dataflow processes on the same clk domain.

Parameters:
DATA_WIDTH, 11, bits per word.
DEPTH, 3, storage entries (≥ 2).
OUT_REG, 0, 1 adds a registered output word after storage; total capacity becomes DEPTH+OUT_REG.
AFULL_THR, DEPTH-1, if_almost_full asserts when occupancy ≥ AFULL_THR.
AEMPTY_THR, 1, if_almost_empty asserts when occupancy ≤ AEMPTY_THR.
CNT_W (localparam), clog2(DEPTH+OUT_REG+1), occupancy width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
if_flush  in  1  synchronous clear of contents; same effect as reset on state.
if_write_ce  in  1  write-side clock enable.
if_write  in  1  write request.
if_din  in  DATA_WIDTH  write data.
if_full_n  out  1  1 = space available.
if_read_ce  in  1  read-side clock enable.
if_read  in  1  read request.
if_dout  out  DATA_WIDTH  head word; valid while if_empty_n=1.
if_empty_n  out  1  1 = data available.
if_num_data_valid  out  CNT_W  current occupancy, including the output register.
if_fifo_cap  out  CNT_W  constant DEPTH+OUT_REG.
if_almost_full  out  1  occupancy ≥ AFULL_THR.
if_almost_empty  out  1  occupancy ≤ AEMPTY_THR.

Behaviour:
- Reset or flush (reset has priority, both synchronous):
  - occupancy = 0; if_empty_n = 0; if_full_n = 1.
  - if_almost_empty = 1; if_almost_full = (AFULL_THR == 0).
  - Storage contents are not cleared.
  - Any push or pop in the same cycle is ignored.
- Effective push = if_write & if_write_ce & if_full_n. Effective pop = if_read & if_read_ce & if_empty_n. Requests against full or empty are ignored; no state change.
- Storage:
  - Shift register; every push shifts in at index 0.
  - Storage pointer p ranges -1..DEPTH-1 (count-1 encoding, all-ones = empty).
  - Read address = p when p ≥ 0, else 0.
- OUT_REG=0:
  - if_dout = srl[p], combinational from the pointer.
  - Push → if_empty_n = 1 on the next cycle (1-cycle latency).
  - Push and pop together: p unchanged, data order preserved, flags unchanged.
  - Full: if_full_n drops on the push that makes occupancy DEPTH.
  - Empty: if_empty_n drops on the pop that makes occupancy 0.
- OUT_REG=1:
  - Output register (oreg, valid bit ov) holds the head word.
  - Load: oreg takes srl[p] and p decrements when (!ov | pop) and storage is non-empty.
  - Bypass: when storage is empty, !ov (or pop), and a push occurs, the word is written to storage first and loaded one cycle later. No direct din→oreg bypass.
  - Latency: write to if_empty_n = 2 cycles.
  - if_dout = oreg; if_empty_n = ov.
  - if_full_n = 0 only when storage holds DEPTH entries and ov = 1.
- Occupancy and flags:
  - Occupancy = (p+1) + ov, registered, updated each cycle as +push −pop.
  - Never wraps: saturation is impossible because of push/pop gating.
  - Almost flags are combinational from the registered occupancy.
- if_dout holds its last value when empty; the bench must not check it while if_empty_n=0.

Optional Feature:
Macro PP_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs if_overflow and if_underflow (1 bit each), both sticky and cleared only by reset (not by flush).
  - if_overflow sets on if_write & if_write_ce while if_full_n=0.
  - if_underflow sets on if_read & if_read_ce while if_empty_n=0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pp_fifo_pkg holds:
  - clog2 function.
  - Count-width helper: cnt_w(depth, oreg).
  - Pointer-empty constant (all-ones).
- One sub-module: pp_pipeline_accel_fifo_srl (DATA_WIDTH, DEPTH), a pure shift register with ce and read address.
- Control, output register and flags stay in the top module.

Test Plan:
1. DEPTH=3, OUT_REG=0: write A,B,C on consecutive cycles.
   - Required: if_full_n=0 after the 3rd push; num_data_valid=3.
   - Then write D with if_full_n=0: ignored.
   - Then read ×3: dout A,B,C in order; if_empty_n=0 after the 3rd read.
2. Hold write and read both asserted for 10 cycles with occupancy 1: occupancy stays 1; output is strict FIFO order; flags never toggle.
3. OUT_REG=1, DEPTH=3: single write at cycle 0 → if_empty_n rises at cycle 2. Fill gives if_fifo_cap=4 and full after 4 pushes; drain returns all 4 words in order.
4. AFULL_THR=2, AEMPTY_THR=1: occupancy 0→3→0. Required: almost_empty=1 at 0–1; almost_full=1 at ≥2.
5. Flush or reset asserted at occupancy 2 together with a write: next cycle occupancy=0, empty_n=0, full_n=1; the write is lost.
6. With PP_FIFO_ERR_FLAGS_EN: write when full → if_overflow=1 and stays set through a flush; read when empty → if_underflow=1; reset clears both.
